// File: rtl/midi_msg_parser.sv
// ============================================================================
// Module  : midi_msg_parser
// Brief   : Byte-level MIDI parser. Tracks running status and emits decoded
//           channel-voice events; real-time bytes are forwarded separately.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module midi_msg_parser #(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_byte,
    input  logic       i_valid,
    output logic       o_evt_valid,
    output logic [2:0] o_evt_type,
    output logic [3:0] o_chan,
    output logic [6:0] o_d1,
    output logic [6:0] o_d2,
    output logic       o_rt_valid,
    output logic [2:0] o_rt_code
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_D1   = 2'd1,
        S_D2   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_run_status;
    logic [7:0] w_run_status_nxt;
    logic       r_run_ok;
    logic       w_run_ok_nxt;
    logic [6:0] r_d1_hold;
    logic [6:0] w_d1_hold_nxt;

    logic       w_emit;
    logic [6:0] w_emit_d1;
    logic [6:0] w_emit_d2;
    logic [2:0] w_emit_type;
    logic       w_chan_ok;
    logic       w_rt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_run_status <= 8'd0;
            r_run_ok     <= 1'b0;
            r_d1_hold    <= 7'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_run_status <= w_run_status_nxt;
            r_run_ok     <= w_run_ok_nxt;
            r_d1_hold    <= w_d1_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_run_status_nxt = r_run_status;
        w_run_ok_nxt     = r_run_ok;
        w_d1_hold_nxt    = r_d1_hold;
        w_emit           = 1'b0;
        w_emit_d1        = r_d1_hold;
        w_emit_d2        = 7'd0;
        w_rt             = 1'b0;

        if (i_valid) begin
            if (i_byte[7:3] == 5'b11111) begin
                // Real-time bytes interleave with messages and touch no parse state.
                w_rt = 1'b1;
            end else if (i_byte[7:4] == 4'hF) begin
                w_run_ok_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end else if (i_byte[7]) begin
                w_run_status_nxt = i_byte;
                w_run_ok_nxt     = 1'b1;
                w_state_nxt      = S_D1;
            end else if (r_run_ok) begin
                case (r_state)
                    S_D1: begin
                        w_d1_hold_nxt = i_byte[6:0];
                        // Program change (C) and channel pressure (D) carry one data byte.
                        if (r_run_status[6:5] == 2'b10) begin
                            w_emit    = 1'b1;
                            w_emit_d1 = i_byte[6:0];
                        end else begin
                            w_state_nxt = S_D2;
                        end
                    end
                    S_D2: begin
                        w_emit      = 1'b1;
                        w_emit_d1   = r_d1_hold;
                        w_emit_d2   = i_byte[6:0];
                        w_state_nxt = S_D1;
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Note on with zero velocity is reported as note off.
    assign w_emit_type = ((r_run_status[6:4] == 3'd1) && (w_emit_d2 == 7'd0))
                         ? 3'd0 : r_run_status[6:4];
    assign w_chan_ok   = OMNI || (r_run_status[3:0] == CHANNEL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_evt_valid <= 1'b0;
            o_evt_type  <= 3'd0;
            o_chan      <= 4'd0;
            o_d1        <= 7'd0;
            o_d2        <= 7'd0;
            o_rt_valid  <= 1'b0;
            o_rt_code   <= 3'd0;
        end else begin
            o_evt_valid <= w_emit && w_chan_ok;
            o_rt_valid  <= w_rt;
            if (w_emit && w_chan_ok) begin
                o_evt_type <= w_emit_type;
                o_chan     <= r_run_status[3:0];
                o_d1       <= w_emit_d1;
                o_d2       <= w_emit_d2;
            end
            if (w_rt) begin
                o_rt_code <= i_byte[2:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_midi_msg_parser.sv
// ============================================================================
// Module  : tb_midi_msg_parser
// Brief   : Scoreboard bench: driver queues expected events/real-time codes,
//           a negedge monitor pops and compares with expected arrival cycle.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_midi_msg_parser;

    typedef struct {
        int         dut;
        int         cyc;
        logic [2:0] t;
        logic [3:0] c;
        logic [6:0] d1;
        logic [6:0] d2;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] r_byte = 8'd0;
    logic [1:0] r_vld = 2'b00;

    logic       evt_v [2];
    logic [2:0] evt_t [2];
    logic [3:0] evt_c [2];
    logic [6:0] evt_d1[2];
    logic [6:0] evt_d2[2];
    logic       rt_v  [2];
    logic [2:0] rt_c  [2];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  qe[$];
    ev_t  qr[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    midi_msg_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) u_omni (
        .clk(clk), .rst_n(rst_n), .i_byte(r_byte), .i_valid(r_vld[0]),
        .o_evt_valid(evt_v[0]), .o_evt_type(evt_t[0]), .o_chan(evt_c[0]),
        .o_d1(evt_d1[0]), .o_d2(evt_d2[0]),
        .o_rt_valid(rt_v[0]), .o_rt_code(rt_c[0])
    );

    midi_msg_parser #(.OMNI(1'b0), .CHANNEL(4'd1)) u_ch1 (
        .clk(clk), .rst_n(rst_n), .i_byte(r_byte), .i_valid(r_vld[1]),
        .o_evt_valid(evt_v[1]), .o_evt_type(evt_t[1]), .o_chan(evt_c[1]),
        .o_d1(evt_d1[1]), .o_d2(evt_d2[1]),
        .o_rt_valid(rt_v[1]), .o_rt_code(rt_c[1])
    );

    // Monitor: compare every output pulse against the queued expectation.
    always @(negedge clk) begin
        ev_t e;
        while (qe.size() > 0 && qe[0].cyc < cyc) begin
            e = qe.pop_front();
            checks++; errors++;
            $display("FAIL evt_missing dut%0d exp cyc %0d type %0d chan %0d d1 %h d2 %h",
                     e.dut, e.cyc, e.t, e.c, e.d1, e.d2);
        end
        while (qr.size() > 0 && qr[0].cyc < cyc) begin
            e = qr.pop_front();
            checks++; errors++;
            $display("FAIL rt_missing dut%0d exp cyc %0d code %0d", e.dut, e.cyc, e.t);
        end
        for (int d = 0; d < 2; d++) begin
            if (evt_v[d] === 1'b1) begin
                checks++;
                if (qe.size() == 0) begin
                    errors++;
                    $display("FAIL evt_unexpected dut%0d cyc %0d got type %0d chan %0d d1 %h d2 %h",
                             d, cyc, evt_t[d], evt_c[d], evt_d1[d], evt_d2[d]);
                end else begin
                    e = qe.pop_front();
                    if (e.dut != d || e.cyc != cyc || evt_t[d] !== e.t || evt_c[d] !== e.c ||
                        evt_d1[d] !== e.d1 || evt_d2[d] !== e.d2) begin
                        errors++;
                        $display("FAIL evt dut%0d got cyc %0d (%0d,%0d,%h,%h) exp dut%0d cyc %0d (%0d,%0d,%h,%h)",
                                 d, cyc, evt_t[d], evt_c[d], evt_d1[d], evt_d2[d],
                                 e.dut, e.cyc, e.t, e.c, e.d1, e.d2);
                    end
                end
            end
            if (rt_v[d] === 1'b1) begin
                checks++;
                if (qr.size() == 0) begin
                    errors++;
                    $display("FAIL rt_unexpected dut%0d cyc %0d got code %0d", d, cyc, rt_c[d]);
                end else begin
                    e = qr.pop_front();
                    if (e.dut != d || e.cyc != cyc || rt_c[d] !== e.t) begin
                        errors++;
                        $display("FAIL rt dut%0d got cyc %0d code %0d exp dut%0d cyc %0d code %0d",
                                 d, cyc, rt_c[d], e.dut, e.cyc, e.t);
                    end
                end
            end
        end
    end

    int sel = 0;

    // kind: 0 = no output expected, 1 = event expected, 2 = real-time expected
    task automatic send(input logic [7:0] b, input int kind = 0, input logic [2:0] t = 3'd0,
                        input logic [3:0] c = 4'd0, input logic [6:0] d1 = 7'd0,
                        input logic [6:0] d2 = 7'd0);
        ev_t e;
        @(negedge clk);
        e.dut = sel; e.cyc = cyc + 1; e.t = t; e.c = c; e.d1 = d1; e.d2 = d2;
        if (kind == 1) qe.push_back(e);
        if (kind == 2) qr.push_back(e);
        r_byte = b;
        r_vld  = (sel == 0) ? 2'b01 : 2'b10;
        @(posedge clk);
        #1 r_vld = 2'b00;
    endtask

    task automatic evt(input logic [7:0] b, input logic [2:0] t, input logic [3:0] c,
                       input logic [6:0] d1, input logic [6:0] d2);
        send(b, 1, t, c, d1, d2);
    endtask

    task automatic chk_outs(input string name, input int d, input logic [27:0] exp);
        logic [27:0] got;
        got = {evt_v[d], rt_v[d], evt_t[d], evt_c[d], evt_d1[d], evt_d2[d], rt_c[d], 3'b000};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h exp %h", name, d, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_outs("reset_outs", 0, 28'd0);
        chk_outs("reset_outs", 1, 28'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_outs("reset_outs", 0, 28'd0);
        chk_outs("reset_outs", 1, 28'd0);
        rst_n = 1'b1;

        sel = 0;
        send(8'h3C);                              // data with no status: ignored
        send(8'h93); send(8'h3C); evt(8'h64, 3'd1, 4'd3, 7'h3C, 7'h64);
        send(8'h90); send(8'h40); evt(8'h7F, 3'd1, 4'd0, 7'h40, 7'h7F);
        send(8'h41); evt(8'h00, 3'd0, 4'd0, 7'h41, 7'h00);
        send(8'hB0); send(8'h07); send(8'hF8, 2, 3'd0);
        evt(8'h50, 3'd3, 4'd0, 7'h07, 7'h50);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outs("hold_fields", 0, {1'b0, 1'b0, 3'd3, 4'd0, 7'h07, 7'h50, 3'd0, 3'b000});
        send(8'hC5); evt(8'h0A, 3'd4, 4'd5, 7'h0A, 7'h00);
        evt(8'h0B, 3'd4, 4'd5, 7'h0B, 7'h00);
        send(8'hE2); send(8'h00); evt(8'h40, 3'd6, 4'd2, 7'h00, 7'h40);
        send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send(8'h3C);
        send(8'h80); send(8'h3C); evt(8'h00, 3'd0, 4'd0, 7'h3C, 7'h00);
        send(8'h91); send(8'h3C); send(8'h92); send(8'h30);
        evt(8'h10, 3'd1, 4'd2, 7'h30, 7'h10);
        send(8'hD3); evt(8'h7F, 3'd5, 4'd3, 7'h7F, 7'h00);
        send(8'hA4); send(8'h10); evt(8'h20, 3'd2, 4'd4, 7'h10, 7'h20);
        send(8'hFC, 2, 3'd4); send(8'hFF, 2, 3'd7); send(8'hFA, 2, 3'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outs("hold_rt_code", 0, {1'b0, 1'b0, 3'd2, 4'd4, 7'h10, 7'h20, 3'd2, 3'b000});

        sel = 1;
        send(8'h90); send(8'h3C); send(8'h40);    // other channel: filtered
        send(8'h91); send(8'h3C); evt(8'h40, 3'd1, 4'd1, 7'h3C, 7'h40);
        send(8'h91);
        do_reset();
        send(8'h3C); send(8'h40);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outs("post_reset_ignore", 1, 28'd0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (qe.size() != 0 || qr.size() != 0) begin
            errors++;
            $display("FAIL pending_expect got %0d evt %0d rt exp 0", qe.size(), qr.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/midi_msg_parser.md
# midi_msg_parser

Byte-level MIDI message parser that sits directly downstream of the synth's serial MIDI receiver. It consumes one received byte per valid strobe and tracks status, running status and data-byte position. It emits one decoded channel-voice event per complete message for the voice allocator and control logic. System real-time bytes are forwarded separately without disturbing message assembly.

## Interface
- OMNI, 1, 1 = accept all channels; 0 = accept only CHANNEL
- CHANNEL, 0, 4-bit channel number used when OMNI = 0
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- i_byte  in  8  received byte; qualified by i_valid
- i_valid  in  1  single-cycle strobe, byte present; may be asserted on consecutive cycles
- o_evt_valid  out  1  single-cycle pulse, event fields valid
- o_evt_type  out  3  0 note off, 1 note on, 2 poly pressure, 3 control change, 4 program change, 5 channel pressure, 6 pitch bend
- o_chan  out  4  channel of event
- o_d1  out  7  first data byte (note, controller, program, pressure, bend LSB)
- o_d2  out  7  second data byte (velocity, value, bend MSB); 0 for 1-data-byte messages
- o_rt_valid  out  1  single-cycle pulse, real-time byte received
- o_rt_code  out  3  i_byte[2:0] of the real-time byte (0 = clock F8, 2 = start FA, 3 = continue FB, 4 = stop FC, 6 = active sense FE, 7 = reset FF)

## Operation
- Internal registers: run_status[7:0] plus run_ok, d1_hold[6:0], state.
- States: S_IDLE (no running status; data bytes discarded), S_D1 (expect first data byte), S_D2 (expect second data byte).
- Byte classes, on i_valid only:
  - 0xF8–0xFF real-time: pulse o_rt_valid with o_rt_code; state, run_status, d1_hold unchanged. Applies in every state, including mid-message.
  - 0xF0–0xF7 system common/SysEx: clear run_ok, go S_IDLE. Following data bytes, including SysEx payload, are discarded until the next channel status.
  - 0x80–0xEF channel status: load run_status, set run_ok, go S_D1. Aborts any partial message silently.
  - 0x00–0x7F data: in S_IDLE, discard. In S_D1, latch d1_hold. If the status high nibble is C or D, emit the event with d2 = 0 and stay S_D1; otherwise go S_D2. In S_D2, emit the event with d1_hold and the byte, then go S_D1 (running status).
- Event fields: o_evt_type = run_status[6:4]; o_chan = run_status[3:0].
- Note on (type 1) with d2 = 0 is reported as type 0 (note off), with d1/d2 unchanged.
- Channel filter: when OMNI = 0 and run_status[3:0] != CHANNEL, the message is fully parsed and state advances identically, but o_evt_valid is not pulsed and the event outputs are not updated.
- No backpressure; every valid byte is consumed.

## Timing
- Reset, checked at clk edge with rst_n = 0:
  - o_evt_valid = 0, o_rt_valid = 0.
  - o_evt_type, o_chan, o_d1, o_d2, o_rt_code = 0.
  - State S_IDLE, run_ok = 0, d1_hold = 0.
- Reset mid-message discards partial bytes; a data byte arriving after reset is ignored until a status byte arrives.
- Latency: o_evt_valid rises in the cycle after the clk edge that samples the completing byte, i.e. registered, 1 cycle.
- o_rt_valid has the same 1-cycle latency.
- Event fields hold their last value until the next emitted event; o_rt_code holds until the next real-time byte.
- Back-to-back i_valid: a completing data byte and the next byte on consecutive cycles must both be handled, giving back-to-back o_evt_valid pulses where applicable.
- o_evt_valid and o_rt_valid never assert in the same cycle, because one byte is consumed per cycle.

## Test plan
- 0x93, 0x3C, 0x64 -> one pulse: type 1, chan 3, d1 0x3C, d2 0x64, one cycle after the third strobe.
- 0x90, 0x40, 0x7F, 0x41, 0x00 (running status) -> two events: (1, 0, 0x40, 0x7F) then (0, 0, 0x41, 0x00).
- 0xB0, 0x07, 0xF8, 0x50 -> o_rt_valid with code 0 after 0xF8, then CC event (3, 0, 0x07, 0x50); a real-time byte mid-message must not corrupt the message.
- 0xC5, 0x0A, 0x0B and 0xE2, 0x00, 0x40 -> program-change events (4, 5, 0x0A, 0) and (4, 5, 0x0B, 0); pitch bend (6, 2, 0x00, 0x40).
- 0xF0, 0x7E, 0x01, 0xF7, 0x3C, then 0x80, 0x3C, 0x00 -> no events until the note off (0, 0, 0x3C, 0x00). Also 0x91, 0x3C, 0x92 (aborted), 0x30, 0x10 -> single event (1, 2, 0x30, 0x10).
- With OMNI = 0, CHANNEL = 1: 0x90, 0x3C, 0x40 gives no pulse; 0x91, 0x3C, 0x40 gives a pulse. Asserting rst_n low between 0x91 and 0x3C, then sending 0x3C, 0x40 gives no event and all outputs 0.
